// File: rtl/alu_issue_stage_if.sv
// Handshake, operand and write-back bundle for alu_issue_stage.
// slave = the issue stage's view, master = the driving side's view.
interface alu_issue_stage_if #(
    parameter int DATA_W = 18,
    parameter int OP_W   = 2,
    parameter int TAG_W  = 3,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_op;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [DATA_W-1:0] in_imm;
    logic              in_use_imm;
    logic [TAG_W-1:0]  in_src_a;
    logic [TAG_W-1:0]  in_src_b;
    logic [TAG_W-1:0]  in_dst;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [OP_W-1:0]   alu_operation;
    logic [TAG_W-1:0]  out_dst;
    logic              wb_valid;
    logic [TAG_W-1:0]  wb_dst;
    logic [DATA_W-1:0] wb_data;
    logic [CNT_W-1:0]  issue_count;

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_imm, in_use_imm,
               in_src_a, in_src_b, in_dst, out_ready,
               wb_valid, wb_dst, wb_data,
        output in_ready, out_valid, A, B, alu_operation, out_dst, issue_count
    );

    modport master (
        output in_valid, in_op, in_a, in_b, in_imm, in_use_imm,
               in_src_a, in_src_b, in_dst, out_ready,
               wb_valid, wb_dst, wb_data,
        input  in_ready, out_valid, A, B, alu_operation, out_dst, issue_count
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Operand issue stage feeding the 18-bit ALU: 2-entry skid buffer, registered outputs.
// Optional write-back forwarding into captured and held operands: define ALU_ISSUE_FWD_EN.
module alu_issue_stage #(
    parameter int DATA_W = 18,
    parameter int OP_W   = 2,
    parameter int TAG_W  = 3,
    parameter int CNT_W  = 16
) (
    input logic              clk,
    input logic              rst_n,
    alu_issue_stage_if.slave bus
);

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [TAG_W-1:0]  src_a;
        logic [TAG_W-1:0]  src_b;
        logic [TAG_W-1:0]  dst;
        logic              use_imm;
    } entry_t;

    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    entry_t           in_entry;
    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0] issue_count_q, issue_count_d;
    logic             accept;
    logic             handshake;

    // Tag 0 is the hardwired zero register, so it never matches a write-back.
    function automatic entry_t forward(input entry_t e);
        entry_t r;
        r = e;
`ifdef ALU_ISSUE_FWD_EN
        if (bus.wb_valid && (bus.wb_dst != '0)) begin
            if (bus.wb_dst == e.src_a) begin
                r.a = bus.wb_data;
            end
            if (!e.use_imm && (bus.wb_dst == e.src_b)) begin
                r.b = bus.wb_data;
            end
        end
`endif
        return r;
    endfunction

`ifndef ALU_ISSUE_FWD_EN
    logic unused_fwd;
    assign unused_fwd = ^{bus.wb_valid, bus.wb_dst, bus.wb_data,
                          main_q.src_a, main_q.src_b, main_q.use_imm};
`endif

    always_comb begin
        in_entry         = '0;
        in_entry.op      = bus.in_op;
        in_entry.a       = bus.in_a;
        in_entry.b       = bus.in_use_imm ? bus.in_imm : bus.in_b;
        in_entry.src_a   = bus.in_src_a;
        in_entry.src_b   = bus.in_src_b;
        in_entry.dst     = bus.in_dst;
        in_entry.use_imm = bus.in_use_imm;
        in_entry         = forward(in_entry);

        accept    = bus.in_valid && !skid_valid_q;
        handshake = main_valid_q && bus.out_ready;

        main_d        = forward(main_q);
        skid_d        = forward(skid_q);
        main_valid_d  = main_valid_q;
        skid_valid_d  = skid_valid_q;
        issue_count_d = issue_count_q + CNT_W'(handshake);

        // A full skid implies in_ready is low, so accept cannot coincide with a refill from skid.
        if (handshake) begin
            if (skid_valid_q) begin
                main_d       = skid_d;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d = in_entry;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (main_valid_q) begin
                skid_d       = in_entry;
                skid_valid_d = 1'b1;
            end else begin
                main_d       = in_entry;
                main_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q        <= '0;
            skid_q        <= '0;
            main_valid_q  <= 1'b0;
            skid_valid_q  <= 1'b0;
            issue_count_q <= '0;
        end else begin
            main_q        <= main_d;
            skid_q        <= skid_d;
            main_valid_q  <= main_valid_d;
            skid_valid_q  <= skid_valid_d;
            issue_count_q <= issue_count_d;
        end
    end

    assign bus.in_ready      = !skid_valid_q;
    assign bus.out_valid     = main_valid_q;
    assign bus.A             = main_q.a;
    assign bus.B             = main_q.b;
    assign bus.alu_operation = main_q.op;
    assign bus.out_dst       = main_q.dst;
    assign bus.issue_count   = issue_count_q;

endmodule
